// File: rtl/imem_refill.sv
// imem_refill: line-refill responder for the L1 instruction cache.
// On a cache miss (c_rd_i) it fetches the enclosing line from memory as BEATS
// beats of BUS_W bits, assembles them into c_data_o and pulses c_dv_o for one
// cycle. A miss that is withdrawn or redirected mid-refill finishes its
// in-flight beat and is dropped without c_dv_o.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   c_addr_i    fetch PC; only bits [63:OFFS] select the line
//   c_rd_i      miss request (level)
//   c_data_o    assembled line, beat k in bits [k*BUS_W +: BUS_W]
//   c_dv_o      one-cycle line-valid strobe
//   m_addr_o    beat byte address (BUS_W/8 aligned)
//   m_rd_o      beat read request, held until m_ack_i
//   m_data_i    beat data, valid with m_ack_i
//   m_ack_i     beat complete
//
// Build option: define IMEM_REFILL_CWF_EN for critical-word-first ordering
// (start at the beat holding c_addr_i, wrap around the line).
module imem_refill #(
  parameter int unsigned LINE  = 256,
  parameter int unsigned BUS_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [63:0]      c_addr_i,
  input  logic             c_rd_i,
  output logic [LINE-1:0]  c_data_o,
  output logic             c_dv_o,
  output logic [63:0]      m_addr_o,
  output logic             m_rd_o,
  input  logic [BUS_W-1:0] m_data_i,
  input  logic             m_ack_i
);

  localparam int unsigned BEATS  = LINE / BUS_W;
  localparam int unsigned OFFS   = $clog2(LINE / 8);
  localparam int unsigned BOFFS  = $clog2(BUS_W / 8);
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned TAG_W  = 64 - OFFS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e            state_q,  state_d;
  logic [TAG_W-1:0]  base_q,   base_d;
  logic [BEAT_W-1:0] beat_q,   beat_d;
  logic [BEAT_W-1:0] cnt_q,    cnt_d;
  logic              stale_q,  stale_d;
  logic              m_rd_q,   m_rd_d;
  logic [63:0]       m_addr_q, m_addr_d;
  logic              c_dv_q,   c_dv_d;
  logic [LINE-1:0]   c_data_q, c_data_d;

  logic [BEAT_W-1:0] start_c;
  logic              abort_c;
  logic              unused_c;

  // Byte address of one beat of the line selected by base.
  function automatic logic [63:0] beat_addr(input logic [TAG_W-1:0]  base,
                                            input logic [BEAT_W-1:0] beat);
    beat_addr = {base, OFFS'(0)} | (64'(beat) << BOFFS);
  endfunction

  // First beat of a refill.
`ifdef IMEM_REFILL_CWF_EN
  assign start_c = c_addr_i[OFFS-1:BOFFS];
`else
  assign start_c = '0;
`endif

  // Offset bits below the line never steer the line choice.
  assign unused_c = ^c_addr_i[OFFS-1:0];

  // Miss withdrawn or moved to another line, now or earlier in this refill.
  assign abort_c = stale_q | ~c_rd_i | (c_addr_i[63:OFFS] != base_q);

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    beat_d   = beat_q;
    cnt_d    = cnt_q;
    stale_d  = stale_q;
    m_rd_d   = m_rd_q;
    m_addr_d = m_addr_q;
    c_dv_d   = 1'b0;
    c_data_d = c_data_q;

    case (state_q)
      IDLE: begin
        if (c_rd_i) begin
          base_d   = c_addr_i[63:OFFS];
          beat_d   = start_c;
          cnt_d    = '0;
          stale_d  = 1'b0;
          m_rd_d   = 1'b1;
          m_addr_d = beat_addr(c_addr_i[63:OFFS], start_c);
          state_d  = FETCH;
        end
      end
      FETCH: begin
        stale_d = abort_c;
        if (m_ack_i) begin
          for (int unsigned k = 0; k < BEATS; k++) begin
            if (beat_q == BEAT_W'(k)) c_data_d[k*BUS_W +: BUS_W] = m_data_i;
          end
          if (abort_c) begin
            m_rd_d  = 1'b0;
            state_d = IDLE;
          end else if (cnt_q == BEAT_W'(BEATS - 1)) begin
            m_rd_d  = 1'b0;
            c_dv_d  = 1'b1;
            state_d = DONE;
          end else begin
            beat_d   = beat_q + BEAT_W'(1);
            cnt_d    = cnt_q + BEAT_W'(1);
            m_addr_d = beat_addr(base_q, beat_q + BEAT_W'(1));
          end
        end
      end
      DONE: begin
        // c_rd_i is still high here for the line just delivered; ignore it.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      base_q   <= '0;
      beat_q   <= '0;
      cnt_q    <= '0;
      stale_q  <= 1'b0;
      m_rd_q   <= 1'b0;
      m_addr_q <= '0;
      c_dv_q   <= 1'b0;
      c_data_q <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      beat_q   <= beat_d;
      cnt_q    <= cnt_d;
      stale_q  <= stale_d;
      m_rd_q   <= m_rd_d;
      m_addr_q <= m_addr_d;
      c_dv_q   <= c_dv_d;
      c_data_q <= c_data_d;
    end
  end

  assign c_data_o = c_data_q;
  assign c_dv_o   = c_dv_q;
  assign m_addr_o = m_addr_q;
  assign m_rd_o   = m_rd_q;

endmodule

// File: tb/tb_imem_refill.sv
// tb_imem_refill: self-checking bench for imem_refill.
// A memory responder with configurable wait states serves beats from a sparse
// random memory; expected lines, beat order and timing come from line/beat
// address arithmetic. Honours IMEM_REFILL_CWF_EN like the design.
module tb_imem_refill;

  localparam int unsigned LINE  = 256;
  localparam int unsigned BUS_W = 64;
  localparam int unsigned BEATS = LINE / BUS_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [63:0]      c_addr_i;
  logic             c_rd_i;
  logic [LINE-1:0]  c_data_o;
  logic             c_dv_o;
  logic [63:0]      m_addr_o;
  logic             m_rd_o;
  logic [BUS_W-1:0] m_data_i;
  logic             m_ack_i;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [63:0]     mem [logic [63:0]];
  logic [63:0]     ack_addr[$];
  int              ack_cyc[$];
  int              req_cyc[$];
  int              dv_cyc[$];
  logic [LINE-1:0] dv_data[$];

  int          fixed_wait = 0;
  int          max_wait   = 0;
  bit          spur_en    = 1'b0;
  int          stab_err   = 0;
  bit          pending    = 1'b0;
  int          wait_left  = 0;
  logic [63:0] req_addr   = '0;

  imem_refill #(.LINE(LINE), .BUS_W(BUS_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .c_addr_i (c_addr_i),
    .c_rd_i   (c_rd_i),
    .c_data_o (c_data_o),
    .c_dv_o   (c_dv_o),
    .m_addr_o (m_addr_o),
    .m_rd_o   (m_rd_o),
    .m_data_i (m_data_i),
    .m_ack_i  (m_ack_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    if (!mem.exists(a)) mem[a] = {$urandom, $urandom};
    return mem[a];
  endfunction

  // Reference line: each beat of the aligned line in its natural slot.
  function automatic logic [LINE-1:0] exp_line(input logic [63:0] a);
    logic [LINE-1:0] l;
    logic [63:0] b;
    b = a & ~64'(LINE / 8 - 1);
    for (int k = 0; k < BEATS; k++) l[k*BUS_W +: BUS_W] = mem_rd(b + 64'(k * (BUS_W / 8)));
    return l;
  endfunction

  // Reference address of the i-th beat issued for a miss at a.
  function automatic logic [63:0] exp_addr(input logic [63:0] a, input int i);
    int start;
    start = 0;
`ifdef IMEM_REFILL_CWF_EN
    start = int'((a % 64'(LINE / 8)) / 64'(BUS_W / 8));
`endif
    return (a & ~64'(LINE / 8 - 1)) + 64'(((start + i) % BEATS) * (BUS_W / 8));
  endfunction

  // Memory responder and c_dv monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (c_dv_o) begin
      dv_cyc.push_back(cyc);
      dv_data.push_back(c_data_o);
    end
    if (!rst_n || !m_rd_o) begin
      pending  = 1'b0;
      m_ack_i  = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
      m_data_i = {$urandom, $urandom};
    end else begin
      if (!pending) begin
        pending   = 1'b1;
        req_addr  = m_addr_o;
        req_cyc.push_back(cyc);
        wait_left = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, max_wait));
      end else if (m_addr_o !== req_addr) begin
        stab_err++;
      end
      if (wait_left == 0) begin
        m_ack_i  = 1'b1;
        m_data_i = mem_rd(m_addr_o);
        ack_addr.push_back(m_addr_o);
        ack_cyc.push_back(cyc);
        pending  = 1'b0;
      end else begin
        m_ack_i  = 1'b0;
        m_data_i = {$urandom, $urandom};
        wait_left--;
      end
    end
  end

  // Raise a miss, wait for c_dv, then drop c_rd in the following cycle.
  task automatic do_refill(input logic [63:0] a, output int k, output bit got);
    int n0;
    n0 = dv_cyc.size();
    @(posedge clk); #1;
    c_addr_i = a;
    c_rd_i   = 1'b1;
    k        = cyc;
    got      = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(posedge clk); #1;
      if (dv_cyc.size() > n0) begin
        got = 1'b1;
        break;
      end
    end
    c_rd_i = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (m_rd_o !== 1'b0) begin errors++; $display("FAIL reset_m_rd got=%0b exp=0", m_rd_o); end
    checks++; if (m_addr_o !== 64'h0) begin errors++; $display("FAIL reset_m_addr got=%0h exp=0", m_addr_o); end
    checks++; if (c_dv_o !== 1'b0) begin errors++; $display("FAIL reset_c_dv got=%0b exp=0", c_dv_o); end
    checks++; if (c_data_o !== '0) begin errors++; $display("FAIL reset_c_data got=%0h exp=0", c_data_o); end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (m_rd_o !== 1'b0 || req_cyc.size() != 0) begin
      errors++; $display("FAIL reset_idle got m_rd=%0b reqs=%0d exp m_rd=0 reqs=0", m_rd_o, req_cyc.size());
    end
  endtask

  task automatic test_basic();
    int k, na, nr, nd;
    bit got;
    logic [LINE-1:0] line;
    fixed_wait = 0; spur_en = 1'b0;
    mem[64'h1000_0020] = 64'hA0; mem[64'h1000_0028] = 64'hA1;
    mem[64'h1000_0030] = 64'hA2; mem[64'h1000_0038] = 64'hA3;
    line = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
    na = ack_addr.size(); nr = req_cyc.size(); nd = dv_cyc.size();
    do_refill(64'h1000_0024, k, got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL basic_timeout got=%0b exp=1", got); end
    checks++; if (dv_cyc[nd] != k + 5) begin errors++; $display("FAIL basic_dv_cycle got=%0d exp=%0d", dv_cyc[nd] - k, 5); end
    checks++; if (dv_data[nd] !== line) begin errors++; $display("FAIL basic_data got=%0h exp=%0h", dv_data[nd], line); end
    for (int i = 0; i < BEATS; i++) begin
      checks++; if (ack_addr[na+i] !== 64'h1000_0020 + 64'(8 * i) || ack_cyc[na+i] != k + 1 + i) begin
        errors++; $display("FAIL basic_beat%0d got addr=%0h cyc=%0d exp addr=%0h cyc=%0d", i,
                           ack_addr[na+i], ack_cyc[na+i] - k, 64'h1000_0020 + 64'(8 * i), 1 + i);
      end
    end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (dv_cyc.size() != nd + 1 || req_cyc.size() != nr + 4) begin
      errors++; $display("FAIL basic_single got dv=%0d reqs=%0d exp dv=1 reqs=4", dv_cyc.size() - nd, req_cyc.size() - nr);
    end
    checks++; if (c_data_o !== line) begin errors++; $display("FAIL basic_hold got=%0h exp=%0h", c_data_o, line); end
  endtask

  task automatic test_async_reset();
    int nr;
    fixed_wait = 4; spur_en = 1'b0;
    @(posedge clk); #1;
    c_addr_i = 64'h1000_0080; c_rd_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (m_rd_o !== 1'b1) begin errors++; $display("FAIL areset_pre got m_rd=%0b exp=1", m_rd_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (m_rd_o !== 1'b0 || c_dv_o !== 1'b0) begin
      errors++; $display("FAIL areset_ctrl got m_rd=%0b c_dv=%0b exp 0 0", m_rd_o, c_dv_o);
    end
    checks++; if (c_data_o !== '0) begin errors++; $display("FAIL areset_data got=%0h exp=0", c_data_o); end
    c_rd_i = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    nr = req_cyc.size();
    repeat (5) @(posedge clk);
    #1;
    checks++; if (m_rd_o !== 1'b0 || req_cyc.size() != nr) begin
      errors++; $display("FAIL areset_idle got m_rd=%0b reqs=%0d exp 0 0", m_rd_o, req_cyc.size() - nr);
    end
  endtask

  task automatic test_wait();
    int k, na, nr, nd, se;
    bit got;
    fixed_wait = 3; spur_en = 1'b1;
    na = ack_addr.size(); nr = req_cyc.size(); nd = dv_cyc.size(); se = stab_err;
    do_refill(64'h1000_0108, k, got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL wait_timeout got=%0b exp=1", got); end
    checks++; if (dv_cyc[nd] != k + 17) begin errors++; $display("FAIL wait_dv_cycle got=%0d exp=17", dv_cyc[nd] - k); end
    checks++; if (stab_err != se) begin errors++; $display("FAIL wait_stable got=%0d exp=0", stab_err - se); end
    checks++; if (dv_data[nd] !== exp_line(64'h1000_0108)) begin
      errors++; $display("FAIL wait_data got=%0h exp=%0h", dv_data[nd], exp_line(64'h1000_0108));
    end
    for (int i = 0; i < BEATS; i++) begin
      checks++; if (ack_addr[na+i] !== exp_addr(64'h1000_0108, i)) begin
        errors++; $display("FAIL wait_addr%0d got=%0h exp=%0h", i, ack_addr[na+i], exp_addr(64'h1000_0108, i));
      end
    end
    repeat (6) @(posedge clk);
    #1;
    checks++; if (m_rd_o !== 1'b0 || req_cyc.size() != nr + 4) begin
      errors++; $display("FAIL wait_spurious got m_rd=%0b reqs=%0d exp 0 4", m_rd_o, req_cyc.size() - nr);
    end
    spur_en = 1'b0;
  endtask

  task automatic test_redirect();
    int na, nr, nd;
    bit got;
    fixed_wait = 2; spur_en = 1'b0;
    na = ack_addr.size(); nr = req_cyc.size(); nd = dv_cyc.size();
    @(posedge clk); #1;
    c_addr_i = 64'h1000_0020; c_rd_i = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(posedge clk); #1;
      if (ack_addr.size() >= na + 2) break;
    end
    c_addr_i = 64'h2000_0000;
    got = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(posedge clk); #1;
      if (dv_cyc.size() > nd) begin got = 1'b1; break; end
    end
    c_rd_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL redir_timeout got=%0b exp=1", got); end
    checks++; if (ack_addr[na+2] !== 64'h1000_0030) begin errors++; $display("FAIL redir_inflight got=%0h exp=10000030", ack_addr[na+2]); end
    checks++; if (ack_addr[na+3] !== 64'h2000_0000) begin errors++; $display("FAIL redir_new got=%0h exp=20000000", ack_addr[na+3]); end
    checks++; if (req_cyc[nr+3] != ack_cyc[na+2] + 2) begin
      errors++; $display("FAIL redir_restart got=%0d exp=2", req_cyc[nr+3] - ack_cyc[na+2]);
    end
    checks++; if (dv_cyc.size() != nd + 1 || ack_addr.size() != na + 7) begin
      errors++; $display("FAIL redir_count got dv=%0d acks=%0d exp dv=1 acks=7", dv_cyc.size() - nd, ack_addr.size() - na);
    end
    checks++; if (dv_data[nd] !== exp_line(64'h2000_0000)) begin
      errors++; $display("FAIL redir_data got=%0h exp=%0h", dv_data[nd], exp_line(64'h2000_0000));
    end
  endtask

  task automatic test_cancel();
    int na, nr, nd;
    fixed_wait = 2; spur_en = 1'b0;
    na = ack_addr.size(); nr = req_cyc.size(); nd = dv_cyc.size();
    @(posedge clk); #1;
    c_addr_i = 64'h1000_0040; c_rd_i = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(posedge clk); #1;
      if (ack_addr.size() >= na + 2) break;
    end
    c_rd_i = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    checks++; if (ack_addr.size() != na + 3 || req_cyc.size() != nr + 3) begin
      errors++; $display("FAIL cancel_count got acks=%0d reqs=%0d exp 3 3", ack_addr.size() - na, req_cyc.size() - nr);
    end
    checks++; if (ack_addr[na+2] !== 64'h1000_0050) begin errors++; $display("FAIL cancel_inflight got=%0h exp=10000050", ack_addr[na+2]); end
    checks++; if (dv_cyc.size() != nd || m_rd_o !== 1'b0) begin
      errors++; $display("FAIL cancel_idle got dv=%0d m_rd=%0b exp 0 0", dv_cyc.size() - nd, m_rd_o);
    end
  endtask

  task automatic test_cwf();
    int k, na, nd;
    bit got;
    fixed_wait = 0; spur_en = 1'b0;
    na = ack_addr.size(); nd = dv_cyc.size();
    do_refill(64'h1000_0034, k, got);
    checks++; if (got !== 1'b1 || dv_cyc[nd] != k + 5) begin
      errors++; $display("FAIL cwf_dv got found=%0b cyc=%0d exp found=1 cyc=5", got, dv_cyc[nd] - k);
    end
    for (int i = 0; i < BEATS; i++) begin
      checks++; if (ack_addr[na+i] !== exp_addr(64'h1000_0034, i)) begin
        errors++; $display("FAIL cwf_addr%0d got=%0h exp=%0h", i, ack_addr[na+i], exp_addr(64'h1000_0034, i));
      end
    end
    checks++; if (dv_data[nd] !== exp_line(64'h1000_0034)) begin
      errors++; $display("FAIL cwf_data got=%0h exp=%0h", dv_data[nd], exp_line(64'h1000_0034));
    end
  endtask

  task automatic test_back_to_back();
    int k, na, nr, nd;
    bit got;
    logic [63:0] a;
    fixed_wait = -1; max_wait = 3; spur_en = 1'b1;
    for (int n = 0; n < 12; n++) begin
      a  = {$urandom, $urandom};
      na = ack_addr.size(); nr = req_cyc.size(); nd = dv_cyc.size();
      do_refill(a, k, got);
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL b2b%0d_timeout got=%0b exp=1", n, got); end
      checks++; if (dv_data[nd] !== exp_line(a)) begin
        errors++; $display("FAIL b2b%0d_data got=%0h exp=%0h", n, dv_data[nd], exp_line(a));
      end
      checks++; if (req_cyc[nr] != k + 1 || dv_cyc[nd] != ack_cyc[na+BEATS-1] + 1) begin
        errors++; $display("FAIL b2b%0d_latency got req=%0d dv=%0d exp req=1 dv=1", n,
                           req_cyc[nr] - k, dv_cyc[nd] - ack_cyc[na+BEATS-1]);
      end
      for (int i = 0; i < BEATS; i++) begin
        checks++; if (ack_addr[na+i] !== exp_addr(a, i) || (i > 0 && req_cyc[nr+i] != ack_cyc[na+i-1] + 1)) begin
          errors++; $display("FAIL b2b%0d_beat%0d got addr=%0h exp addr=%0h", n, i, ack_addr[na+i], exp_addr(a, i));
        end
      end
    end
    spur_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; c_rd_i = 1'b0; c_addr_i = '0; m_ack_i = 1'b0; m_data_i = '0;
    test_reset();
    test_basic();
    test_async_reset();
    test_wait();
    test_redirect();
    test_cancel();
    test_cwf();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
